// File: rtl/ex_stage_md.sv
// ex_stage_md: RV execute stage with forwarding, branch resolution, iterative RV32M unit and EX/MEM register

// alu: base-ISA arithmetic/logic operations
module alu #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [3:0]      ctrl_i,
  output logic [XLEN-1:0] y_o
);
  localparam int SW = $clog2(XLEN);
  logic [SW-1:0] sh;
  assign sh = b_i[SW-1:0];
  // operation select: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu, 10 pass b
  always_comb begin
    case (ctrl_i)
      4'd0:    y_o = a_i + b_i;
      4'd1:    y_o = a_i - b_i;
      4'd2:    y_o = a_i & b_i;
      4'd3:    y_o = a_i | b_i;
      4'd4:    y_o = a_i ^ b_i;
      4'd5:    y_o = a_i << sh;
      4'd6:    y_o = a_i >> sh;
      4'd7:    y_o = $unsigned($signed(a_i) >>> sh);
      4'd8:    y_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      4'd9:    y_o = {{(XLEN-1){1'b0}}, a_i < b_i};
      4'd10:   y_o = b_i;
      default: y_o = '0;
    endcase
  end
endmodule

module ex_stage_md #(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [1:0]      i_fwd1_sel,
  input  logic [1:0]      i_fwd2_sel,
  input  logic [XLEN-1:0] i_ex_result,
  input  logic [XLEN-1:0] i_w_data,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_sel1,
  input  logic            i_sel2,
  input  logic [3:0]      i_alu_ctrl,
  input  logic            i_md_en,
  input  logic [2:0]      i_func3,
  input  logic [4:0]      i_rd,
  input  logic            i_reg_write,
  input  logic            i_mem_write,
  input  logic            i_load,
  input  logic [1:0]      i_result_src,
  input  logic            i_branch,
  input  logic            i_jal,
  input  logic            i_jalr,
  output logic            o_boj,
  output logic            o_jalr,
  output logic [XLEN-1:0] o_imm,
  output logic [XLEN-1:0] o_result,
  output logic            o_stall,
  output logic            o_busy,
  output logic [XLEN-1:0] o_result_m,
  output logic [XLEN-1:0] o_store_data_m,
  output logic [XLEN-1:0] o_pc_m,
  output logic [2:0]      o_func3_m,
  output logic [4:0]      o_rd_m,
  output logic [1:0]      o_result_src_m,
  output logic            o_valid_m,
  output logic            o_reg_write_m,
  output logic            o_mem_write_m,
  output logic            o_load_m
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d, prod;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
  logic [2:0] f3_q, f3_d;
  logic [XLEN-1:0] fwd1, fwd2, op1, op2, alu_y, am, bm, quo, rem, md_res, div_rem;
  logic [XLEN:0] mul_sum, div_sh;
  logic md_req, taken, sa_in, sb_in, sa, sb, div_ge, bubble;

  function automatic logic sgn_a(input logic [2:0] f);
    return f[2] ? !f[0] : (f[1] ^ f[0]);
  endfunction

  function automatic logic sgn_b(input logic [2:0] f);
    return f[2] ? !f[0] : (f == 3'b001);
  endfunction

  assign fwd1 = i_fwd1_sel == 2'b01 ? i_ex_result : i_fwd1_sel == 2'b10 ? i_w_data : i_rs1_data;
  assign fwd2 = i_fwd2_sel == 2'b01 ? i_ex_result : i_fwd2_sel == 2'b10 ? i_w_data : i_rs2_data;
  assign op1 = i_sel1 ? fwd1 : i_pc;
  assign op2 = i_sel2 ? i_imm : fwd2;

  alu #(.XLEN(XLEN)) u_alu (.a_i(op1), .b_i(op2), .ctrl_i(i_alu_ctrl), .y_o(alu_y));

  assign taken = i_func3 == 3'b000 ? fwd1 == fwd2 :
                 i_func3 == 3'b001 ? fwd1 != fwd2 :
                 i_func3 == 3'b100 ? $signed(fwd1) < $signed(fwd2) :
                 i_func3 == 3'b101 ? $signed(fwd1) >= $signed(fwd2) :
                 i_func3 == 3'b110 ? fwd1 < fwd2 :
                 i_func3 == 3'b111 ? fwd1 >= fwd2 : 1'b0;
  assign o_boj = i_valid & !i_flush & ((i_branch & taken) | i_jal);
  assign o_jalr = i_valid & !i_flush & i_jalr;
  assign o_imm = i_imm;

  assign md_req = i_valid & i_md_en & EN_M & !i_flush;
  assign sa_in = sgn_a(i_func3) & op1[XLEN-1];
  assign sb_in = sgn_b(i_func3) & op2[XLEN-1];
  assign am = sa_in ? -op1 : op1;
  assign bm = sb_in ? -op2 : op2;

  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign div_sh = acc_q[2*XLEN-1:XLEN-1];
  assign div_ge = div_sh >= {1'b0, m_q};
  assign div_rem = div_ge ? div_sh[XLEN-1:0] - m_q : div_sh[XLEN-1:0];

  assign sa = sgn_a(f3_q) & a_q[XLEN-1];
  assign sb = sgn_b(f3_q) & b_q[XLEN-1];
  assign prod = (sa ^ sb) ? -acc_q : acc_q;
  assign quo = b_q == '0 ? '1 : (sa ^ sb) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem = b_q == '0 ? a_q : sa ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  assign md_res = f3_q[2] ? (f3_q[1] ? rem : quo) : (f3_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

  assign o_stall = rst_n & ((state_q == IDLE & md_req) | state_q == BUSY);
  assign o_busy = state_q != IDLE;
  assign o_result = state_q == DONE ? md_res : alu_y;
  assign bubble = i_flush | !i_valid | o_stall;

  // MD sequencing: latch magnitudes in IDLE, one shift-add or restoring-divide step per BUSY cycle
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    a_d = a_q;
    b_d = b_q;
    m_d = m_q;
    f3_d = f3_q;
    if (state_q == IDLE && md_req) begin
      state_d = BUSY;
      cnt_d = '0;
      a_d = op1;
      b_d = op2;
      f3_d = i_func3;
      m_d = i_func3[2] ? bm : am;
      acc_d = {{XLEN{1'b0}}, i_func3[2] ? am : bm};
    end else if (state_q == BUSY) begin
      acc_d = f3_q[2] ? {div_rem, acc_q[XLEN-2:0], div_ge} : {mul_sum, acc_q[XLEN-1:1]};
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == CW'(XLEN-1) ? DONE : BUSY;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    if (i_flush) state_d = IDLE;
  end

  // MD state and operand registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      a_q <= '0;
      b_q <= '0;
      m_q <= '0;
      f3_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      a_q <= a_d;
      b_q <= b_d;
      m_q <= m_d;
      f3_q <= f3_d;
    end
  end

  // EX/MEM register: bubbles clear control only, data fields hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_result_m <= '0;
      o_store_data_m <= '0;
      o_pc_m <= '0;
      o_func3_m <= '0;
      o_rd_m <= '0;
      o_result_src_m <= '0;
      o_valid_m <= 1'b0;
      o_reg_write_m <= 1'b0;
      o_mem_write_m <= 1'b0;
      o_load_m <= 1'b0;
    end else if (bubble) begin
      o_valid_m <= 1'b0;
      o_reg_write_m <= 1'b0;
      o_mem_write_m <= 1'b0;
      o_load_m <= 1'b0;
    end else begin
      o_result_m <= o_result;
      o_store_data_m <= fwd2;
      o_pc_m <= i_pc;
      o_func3_m <= i_func3;
      o_rd_m <= i_rd;
      o_result_src_m <= i_result_src;
      o_valid_m <= 1'b1;
      o_reg_write_m <= i_reg_write;
      o_mem_write_m <= i_mem_write;
      o_load_m <= i_load;
    end
  end
endmodule

// File: tb/tb_ex_stage_md.sv
// tb_ex_stage_md: randomized self-checking bench for ex_stage_md against an arithmetic reference model
module tb_ex_stage_md;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_valid, i_flush, i_sel1, i_sel2, i_md_en, i_reg_write, i_mem_write, i_load, i_branch, i_jal, i_jalr;
  logic [31:0] i_rs1_data, i_rs2_data, i_ex_result, i_w_data, i_pc, i_imm;
  logic [1:0] i_fwd1_sel, i_fwd2_sel, i_result_src;
  logic [3:0] i_alu_ctrl;
  logic [2:0] i_func3;
  logic [4:0] i_rd;
  logic o_boj, o_jalr, o_stall, o_busy, o_valid_m, o_reg_write_m, o_mem_write_m, o_load_m;
  logic [31:0] o_imm, o_result, o_result_m, o_store_data_m, o_pc_m;
  logic [2:0] o_func3_m;
  logic [4:0] o_rd_m;
  logic [1:0] o_result_src_m;
  int checks = 0, errors = 0;
  logic [31:0] e_res, e_sd, e_pc;
  logic [13:0] e_ctl;

  always #5 clk = ~clk;

  ex_stage_md #(.XLEN(32), .EN_M(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_flush(i_flush),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_fwd1_sel(i_fwd1_sel), .i_fwd2_sel(i_fwd2_sel),
    .i_ex_result(i_ex_result), .i_w_data(i_w_data), .i_pc(i_pc), .i_imm(i_imm),
    .i_sel1(i_sel1), .i_sel2(i_sel2), .i_alu_ctrl(i_alu_ctrl), .i_md_en(i_md_en), .i_func3(i_func3),
    .i_rd(i_rd), .i_reg_write(i_reg_write), .i_mem_write(i_mem_write), .i_load(i_load),
    .i_result_src(i_result_src), .i_branch(i_branch), .i_jal(i_jal), .i_jalr(i_jalr),
    .o_boj(o_boj), .o_jalr(o_jalr), .o_imm(o_imm), .o_result(o_result), .o_stall(o_stall), .o_busy(o_busy),
    .o_result_m(o_result_m), .o_store_data_m(o_store_data_m), .o_pc_m(o_pc_m), .o_func3_m(o_func3_m),
    .o_rd_m(o_rd_m), .o_result_src_m(o_result_src_m), .o_valid_m(o_valid_m), .o_reg_write_m(o_reg_write_m),
    .o_mem_write_m(o_mem_write_m), .o_load_m(o_load_m)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] md_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    case (f)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: return b == 0 ? 32'hFFFFFFFF : 32'(sa / sb);
      3'd5: return b == 0 ? 32'hFFFFFFFF : a / b;
      3'd6: return b == 0 ? a : 32'(sa % sb);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return 32'($signed(a) >>> b[4:0]);
      4'd8: return {31'b0, $signed(a) < $signed(b)};
      4'd9: return {31'b0, a < b};
      4'd10: return b;
      default: return 32'b0;
    endcase
  endfunction

  function automatic logic br_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic clear_inputs();
    {i_valid, i_flush, i_sel1, i_sel2, i_md_en, i_reg_write, i_mem_write, i_load, i_branch, i_jal, i_jalr} = '0;
    {i_rs1_data, i_rs2_data, i_ex_result, i_w_data, i_pc, i_imm} = '0;
    {i_fwd1_sel, i_fwd2_sel, i_result_src, i_alu_ctrl, i_func3, i_rd} = '0;
  endtask

  task automatic run_md(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp = md_ref(f, a, b);
    int n = 0;
    i_valid = 1; i_md_en = 1; i_flush = 0; i_func3 = f; i_sel1 = 1; i_sel2 = 0;
    i_fwd1_sel = 0; i_fwd2_sel = 0; i_rs1_data = a; i_rs2_data = b; i_reg_write = 1;
    i_branch = 0; i_jal = 0; i_jalr = 0; i_rd = 5'd9;
    #1;
    while (o_stall && n < 100) begin
      if (n == 5) chk({tag, " bubble"}, o_valid_m, 0);
      tick();
      n++;
      i_rs1_data = $urandom; i_rs2_data = $urandom; i_ex_result = $urandom; i_w_data = $urandom;
      #1;
    end
    chk({tag, " stall_cycles"}, n, 33);
    chk({tag, " done_busy"}, o_busy, 1);
    chk({tag, " o_result"}, o_result, exp);
    tick();
    chk({tag, " o_result_m"}, o_result_m, exp);
    chk({tag, " valid_m"}, o_valid_m, 1);
    chk({tag, " idle"}, o_busy, 0);
    e_res = exp;
    i_valid = 0; i_md_en = 0;
  endtask

  task automatic br(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic bra, input logic jal, input logic fl, input logic exp);
    i_valid = 1; i_md_en = 0; i_fwd1_sel = 0; i_fwd2_sel = 0; i_func3 = f;
    i_rs1_data = a; i_rs2_data = b; i_branch = bra; i_jal = jal; i_jalr = 0; i_flush = fl;
    #1;
    chk(tag, o_boj, exp);
    i_valid = 0; i_branch = 0; i_jal = 0; i_flush = 0;
  endtask

  initial begin
    logic [31:0] f1, f2, o1, o2, er;
    logic [2:0] f;
    logic [31:0] a, b;
    clear_inputs();
    #12;
    chk("rst result_m", o_result_m, 0);
    chk("rst valid_m", o_valid_m, 0);
    chk("rst stall", o_stall, 0);
    chk("rst busy", o_busy, 0);
    chk("rst ctl", {o_valid_m, o_reg_write_m, o_mem_write_m, o_load_m, o_result_src_m, o_func3_m, o_rd_m}, 0);
    rst_n = 1;
    tick();
    i_valid = 1; i_sel1 = 1; i_fwd1_sel = 2'b01; i_ex_result = 5; i_sel2 = 0; i_fwd2_sel = 0;
    i_rs2_data = 7; i_alu_ctrl = 0; i_reg_write = 1; i_rd = 3; i_pc = 32'h100;
    #1;
    chk("add o_result", o_result, 12);
    chk("add stall", o_stall, 0);
    tick();
    chk("add o_result_m", o_result_m, 12);
    chk("add valid_m", o_valid_m, 1);
    chk("add rd_m", o_rd_m, 3);
    i_valid = 0;
    run_md("mul -3x7", 3'd0, 32'hFFFFFFFD, 7);
    run_md("mulh", 3'd1, 32'h80000000, 32'h80000000);
    run_md("mulhu", 3'd3, 32'h80000000, 32'h80000000);
    run_md("mulhsu", 3'd2, 32'hFFFFFFFF, 2);
    run_md("div 7/0", 3'd4, 7, 0);
    run_md("rem 7/0", 3'd6, 7, 0);
    run_md("div ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF);
    run_md("rem ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF);
    run_md("divu", 3'd5, 100, 7);
    run_md("remu", 3'd7, 100, 7);
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        3: b = $urandom_range(0, 15) - 8;
        default: ;
      endcase
      run_md($sformatf("md%0d f%0d", i, f), f, a, b);
    end
    br("beq", 3'd0, 32'h55, 32'h55, 1, 0, 0, 1);
    br("bne eq", 3'd1, 32'h55, 32'h55, 1, 0, 0, 0);
    br("bltu", 3'd6, 1, 32'hFFFFFFFF, 1, 0, 0, 1);
    br("blt", 3'd4, 1, 32'hFFFFFFFF, 1, 0, 0, 0);
    br("jal", 3'd2, 0, 0, 0, 1, 0, 1);
    br("jal flush", 3'd2, 0, 0, 0, 1, 1, 0);
    br("beq flush", 3'd0, 9, 9, 1, 0, 1, 0);
    for (int i = 0; i < 200; i++) begin
      i_valid = i == 0 || $urandom_range(0, 3) != 0;
      i_flush = i != 0 && $urandom_range(0, 5) == 0;
      i_md_en = 0;
      i_fwd1_sel = 2'($urandom); i_fwd2_sel = 2'($urandom);
      i_sel1 = 1'($urandom); i_sel2 = 1'($urandom);
      i_rs1_data = $urandom; i_rs2_data = $urandom; i_ex_result = $urandom; i_w_data = $urandom;
      i_pc = $urandom; i_imm = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 40);
      if ($urandom_range(0, 3) == 0) i_rs2_data = i_rs1_data;
      i_alu_ctrl = 4'($urandom_range(0, 11)); i_func3 = 3'($urandom); i_rd = 5'($urandom);
      i_reg_write = 1'($urandom); i_mem_write = 1'($urandom); i_load = 1'($urandom);
      i_result_src = 2'($urandom); i_branch = 1'($urandom); i_jal = 1'($urandom); i_jalr = 1'($urandom);
      f1 = i_fwd1_sel == 1 ? i_ex_result : i_fwd1_sel == 2 ? i_w_data : i_rs1_data;
      f2 = i_fwd2_sel == 1 ? i_ex_result : i_fwd2_sel == 2 ? i_w_data : i_rs2_data;
      o1 = i_sel1 ? f1 : i_pc;
      o2 = i_sel2 ? i_imm : f2;
      er = alu_ref(i_alu_ctrl, o1, o2);
      #1;
      chk($sformatf("alu%0d result", i), o_result, er);
      chk($sformatf("alu%0d boj", i), o_boj, i_valid & !i_flush & ((i_branch & br_ref(i_func3, f1, f2)) | i_jal));
      chk($sformatf("alu%0d jalr", i), o_jalr, i_valid & !i_flush & i_jalr);
      chk($sformatf("alu%0d stall", i), o_stall, 0);
      chk($sformatf("alu%0d imm", i), o_imm, i_imm);
      if (i_valid && !i_flush) begin
        e_res = er; e_sd = f2; e_pc = i_pc;
        e_ctl = {1'b1, i_reg_write, i_mem_write, i_load, i_result_src, i_func3, i_rd};
      end else e_ctl[13:10] = 4'b0;
      tick();
      chk($sformatf("alu%0d result_m", i), o_result_m, e_res);
      chk($sformatf("alu%0d store_m", i), o_store_data_m, e_sd);
      chk($sformatf("alu%0d pc_m", i), o_pc_m, e_pc);
      chk($sformatf("alu%0d ctl_m", i), {o_valid_m, o_reg_write_m, o_mem_write_m, o_load_m, o_result_src_m, o_func3_m, o_rd_m}, e_ctl);
    end
    clear_inputs();
    i_valid = 1; i_md_en = 1; i_func3 = 3'd4; i_sel1 = 1; i_rs1_data = 100; i_rs2_data = 7; i_reg_write = 1;
    repeat (10) tick();
    chk("flush pre busy", o_busy, 1);
    chk("flush pre stall", o_stall, 1);
    i_flush = 1; i_jal = 1;
    #1;
    chk("flush boj", o_boj, 0);
    tick();
    chk("flush idle", o_busy, 0);
    chk("flush valid_m", o_valid_m, 0);
    chk("flush result_m hold", o_result_m, e_res);
    i_flush = 0; i_jal = 0; i_valid = 0; i_md_en = 0;
    tick();
    i_valid = 1; i_md_en = 1; i_func3 = 3'd0; i_rs1_data = 3; i_rs2_data = 5;
    repeat (5) tick();
    chk("rstmid pre busy", o_busy, 1);
    rst_n = 0;
    #1;
    chk("rstmid stall", o_stall, 0);
    chk("rstmid busy", o_busy, 0);
    chk("rstmid result_m", o_result_m, 0);
    chk("rstmid ctl", {o_valid_m, o_reg_write_m, o_mem_write_m, o_load_m, o_result_src_m, o_func3_m, o_rd_m}, 0);
    i_valid = 0; i_md_en = 0;
    #2 rst_n = 1;
    tick();
    chk("post rst busy", o_busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_stage_md.md
# ex_stage_md

Parametrised execute stage for the RV pipeline, extending the single-cycle EX stage with an iterative RV32M multiply/divide unit. It also adds operand latching, a stall output towards IF/ID and flush handling. It sits between the ID/EX and EX/MEM boundaries, reuses the codebase `alu` module for base-ISA operations and registers all results into the EX/MEM register.

## Interface
Parameters:
- XLEN, 32, datapath width (≥8, even).
- EN_M, 1, 1 = M extension implemented; 0 = `i_md_en` ignored (op treated as ALU op).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_valid  in  1  instruction in EX is valid.
- i_flush  in  1  squash the instruction in EX (synchronous).
- i_rs1_data, i_rs2_data  in  XLEN  register-file operands.
- i_fwd1_sel, i_fwd2_sel  in  2  forwarding select: 00 regfile, 01 i_ex_result, 10 i_w_data, 11 regfile.
- i_ex_result, i_w_data  in  XLEN  forwarded MEM-stage / WB-stage data.
- i_pc, i_imm  in  XLEN  PC and immediate.
- i_sel1, i_sel2  in  1  op1 = sel1 ? fwd1 : pc; op2 = sel2 ? imm : fwd2.
- i_alu_ctrl  in  4  `alu` control code.
- i_md_en  in  1  instruction is an M-extension op.
- i_func3  in  3  branch condition / M op / load-store size.
- i_rd  in  5  destination register.
- i_reg_write, i_mem_write, i_load  in  1  control passed to MEM.
- i_result_src  in  2  WB result select, passed to MEM.
- i_branch, i_jal, i_jalr  in  1  control-flow type.
- o_boj  out  1  redirect PC to pc+imm.
- o_jalr  out  1  redirect PC to o_result.
- o_imm  out  XLEN  i_imm pass-through.
- o_result  out  XLEN  combinational EX result.
- o_stall  out  1  hold IF/ID/ID-EX.
- o_busy  out  1  MD unit not IDLE.
- o_result_m, o_store_data_m, o_pc_m  out  XLEN  EX/MEM registers.
- o_func3_m  out  3, o_rd_m  out  5, o_result_src_m  out  2  EX/MEM registers.
- o_valid_m, o_reg_write_m, o_mem_write_m, o_load_m  out  1  EX/MEM registers.

## Operation
- `md_req` = i_valid & i_md_en & EN_M & !i_flush.
- Branch condition on fwd1/fwd2 by i_func3:
  - 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu.
  - Others: not taken.
- o_boj = i_valid & !i_flush & ((i_branch & taken) | i_jal).
- o_jalr = i_valid & !i_flush & i_jalr.
- M ops by i_func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Signed ops: operands converted to magnitudes; unsigned shift-add multiply (2·XLEN product) or restoring divide, one bit per cycle; sign fixed in DONE.
- Special cases, RISC-V defined:
  - Divide by zero: quotient all-ones, remainder = dividend.
  - Most-negative ÷ −1: quotient = dividend, remainder 0.
  - Same latency as normal ops.
- FSM:
  - IDLE: on md_req, latch op1/op2 (post-forwarding) and func3, clear counter, go BUSY.
  - BUSY: one iteration per cycle; after XLEN iterations go DONE.
  - DONE: present result; go IDLE.
  - i_flush in any state: go IDLE, discard the partial result.
- o_stall = md_req in IDLE, or state == BUSY. o_stall is 0 in DONE.
- o_busy = state != IDLE.
- o_result = MD result in DONE, otherwise `alu` output.
- EX/MEM register on each edge:
  - Bubble (valid/reg_write/mem_write/load = 0, data fields hold) when i_flush, !i_valid or o_stall.
  - Otherwise captures o_result, fwd2 (store data), i_pc, i_func3, i_rd and the control inputs, with o_valid_m = 1.
- DONE uses latched operands only. Forwarding inputs may change while the op is stalled.

## Timing
- Reset: state IDLE, counter 0, all EX/MEM outputs 0, o_stall/o_busy 0.
- Reset asserted mid-op aborts the op with no EX/MEM write.
- Non-M op: combinational through EX, registered into EX/MEM at the next edge (1 cycle).
- M op presented at cycle 0:
  - o_stall = 1 for cycles 0..XLEN.
  - DONE in cycle XLEN+1.
  - Result visible on o_result_m after the edge ending cycle XLEN+1.
  - Total EX occupancy XLEN+2 cycles.
- Back-to-back M ops: the second starts from IDLE in the cycle after DONE, with no extra gap.
- i_flush has priority over md_req and DONE.

## Test plan
- ADD, with op1 forwarded from i_ex_result = 5 (sel 01) and rs2 = 7 → o_result = 12; next edge o_result_m = 12, o_valid_m = 1, o_stall never high.
- MUL −3 × 7 (XLEN = 32):
  - o_stall high exactly 33 cycles, DONE in cycle 33.
  - o_result_m = 0xFFFFFFEB; bubbles (o_valid_m = 0) during the stall.
- MULH/MULHU 0x80000000 × 0x80000000 → 0x40000000 / 0x40000000; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 7/0 → 0xFFFFFFFF; REM 7/0 → 7; DIV 0x80000000/−1 → 0x80000000; REM → 0; DIVU 100/7 → 14; REMU → 2.
- BEQ equal operands → o_boj = 1; BLTU 1 vs 0xFFFFFFFF → taken; JAL → o_boj = 1; i_flush = 1 forces o_boj = 0.
- i_flush at BUSY cycle 10 of a DIV → IDLE next edge, no EX/MEM write. rst_n low mid-MUL → all outputs 0 immediately, o_stall = 0.
